// File: rtl/asm_serial_pkg.sv
// Shared types and parameter defaults for the framed serial transmitter.
package asm_serial_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int unsigned DATA_W_DEF     = 3;
  localparam int unsigned BIT_CYCLES_DEF = 2;

endpackage

// File: rtl/asm_serial_tx_if.sv
// Word handshake between a data source and the serial transmitter.
interface asm_serial_tx_if
  import asm_serial_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              ready_o;

  modport master (output data_i, output valid_i, input ready_o);
  modport slave  (input data_i, input valid_i, output ready_o);

endinterface

// File: rtl/asm_serial_tx_bit_timer.sv
// Bit-period prescaler: counts 0..BIT_CYCLES-1, flags the terminal count.
module bit_timer
  import asm_serial_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = BIT_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clr_i,
  output logic tc_c,
  output logic tc_next_c
);

  localparam int unsigned CNT_W = $clog2(BIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Wrap on terminal so back-to-back bits in DATA need no explicit clear
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tc_c) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign tc_c      = (cnt_q == LAST);
  assign tc_next_c = (cnt_d == LAST);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/asm_serial_tx.sv
// Framed serial transmitter: start bit (1), DATA_W bits MSB first, stop bit (0),
// each bit held BIT_CYCLES clocks; line idles low.
module asm_serial_tx
  import asm_serial_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned BIT_CYCLES = BIT_CYCLES_DEF
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  asm_serial_tx_if.slave  bus,
  output logic            tx_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam int unsigned IDX_W = $clog2(DATA_W + 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              tx_d, busy_d, ready_d, done_d;
  logic              tc, tc_next, timer_clr;

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr_i    (timer_clr),
    .tc_c     (tc),
    .tc_next_c(tc_next)
  );

  // Next-state, shift register and bit index
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.valid_i && bus.ready_o) begin
          shift_d = bus.data_i;
          state_d = START;
        end
      end
      START: begin
        if (tc) begin
          state_d = DATA;
          idx_d   = IDX_W'(DATA_W - 1);
        end
      end
      DATA: begin
        if (tc) begin
          if (idx_q == '0) begin
            state_d = STOP;
          end else begin
            shift_d = shift_q << 1;
            idx_d   = idx_q - IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (tc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign timer_clr = (state_q == IDLE) || (state_d != state_q);

  // Output values for the coming cycle, so every output leaves a flop
  always_comb begin
    tx_d    = 1'b0;
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    done_d  = (state_d == STOP) && tc_next;
    unique case (state_d)
      START:   tx_d = 1'b1;
      DATA:    tx_d = shift_d[DATA_W-1];
      default: tx_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      tx_o        <= 1'b0;
      busy_o      <= 1'b0;
      bus.ready_o <= 1'b1;
      done_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      tx_o        <= tx_d;
      busy_o      <= busy_d;
      bus.ready_o <= ready_d;
      done_o      <= done_d;
    end
  end

endmodule

// File: tb/tb_asm_serial_tx.sv
// Bench for asm_serial_tx: BIT_CYCLES=2 and BIT_CYCLES=1 instances checked every
// cycle against a frame-offset model, plus literal frame patterns.
module tb_asm_serial_tx;
  import asm_serial_pkg::*;

  localparam int unsigned W = DATA_W_DEF;

  logic clk_i    = 1'b0;
  logic reset_ni = 1'b1;
  always #5 clk_i = ~clk_i;

  asm_serial_tx_if #(.DATA_W(W)) bus_a ();
  asm_serial_tx_if #(.DATA_W(W)) bus_b ();
  logic tx_a, busy_a, done_a, tx_b, busy_b, done_b;

  asm_serial_tx #(.DATA_W(W), .BIT_CYCLES(2)) dut_a (
    .clk_i(clk_i), .reset_ni(reset_ni), .bus(bus_a.slave),
    .tx_o(tx_a), .busy_o(busy_a), .done_o(done_a)
  );
  asm_serial_tx #(.DATA_W(W), .BIT_CYCLES(1)) dut_b (
    .clk_i(clk_i), .reset_ni(reset_ni), .bus(bus_b.slave),
    .tx_o(tx_b), .busy_o(busy_b), .done_o(done_b)
  );

  int tests  = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: per instance, the cycle of the accept edge and the latched word
  bit          act [2];
  int          acc [2];
  logic [W-1:0] mdat [2];
  int          bcs [2];

  logic ctx [1:32];
  logic cdn [1:32];
  logic crd [1:32];

  function automatic int flen(int d);
    return (W + 2) * bcs[d];
  endfunction

  function automatic int jof(int d, int c);
    return c - acc[d] + 1;
  endfunction

  function automatic bit in_frame(int d, int c);
    return act[d] && jof(d, c) >= 1 && jof(d, c) <= flen(d);
  endfunction

  function automatic logic exp_tx(int d, int c);
    int j, bc, k;
    if (!in_frame(d, c)) return 1'b0;
    j  = jof(d, c);
    bc = bcs[d];
    if (j <= bc) return 1'b1;
    if (j <= (W + 1) * bc) begin
      k = (j - bc - 1) / bc;
      return mdat[d][W-1-k];
    end
    return 1'b0;
  endfunction

  function automatic logic exp_done(int d, int c);
    return in_frame(d, c) && jof(d, c) == flen(d);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("a_tx",    32'(tx_a),          32'(exp_tx(0, cyc)));
    chk("a_busy",  32'(busy_a),        32'(in_frame(0, cyc)));
    chk("a_ready", 32'(bus_a.ready_o), 32'(!in_frame(0, cyc)));
    chk("a_done",  32'(done_a),        32'(exp_done(0, cyc)));
    chk("b_tx",    32'(tx_b),          32'(exp_tx(1, cyc)));
    chk("b_busy",  32'(busy_b),        32'(in_frame(1, cyc)));
    chk("b_ready", 32'(bus_b.ready_o), 32'(!in_frame(1, cyc)));
    chk("b_done",  32'(done_b),        32'(exp_done(1, cyc)));
  endtask

  // One clock: model sees the accept edge, outputs compared at the falling edge
  task automatic tick();
    @(posedge clk_i);
    cyc++;
    if (reset_ni && bus_a.valid_i && !in_frame(0, cyc - 1)) begin
      act[0] = 1'b1; acc[0] = cyc; mdat[0] = bus_a.data_i;
    end
    if (reset_ni && bus_b.valid_i && !in_frame(1, cyc - 1)) begin
      act[1] = 1'b1; acc[1] = cyc; mdat[1] = bus_b.data_i;
    end
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic send(input int d, input logic [W-1:0] v);
    logic rdy;
    rdy = (d == 0) ? bus_a.ready_o : bus_b.ready_o;
    for (int i = 0; i < 40 && !rdy; i++) begin
      tick();
      rdy = (d == 0) ? bus_a.ready_o : bus_b.ready_o;
    end
    chk("ready_wait", 32'(rdy), 32'd1);
    if (d == 0) begin bus_a.data_i = v; bus_a.valid_i = 1'b1; end
    else        begin bus_b.data_i = v; bus_b.valid_i = 1'b1; end
  endtask

  task automatic cap(input int d, input int from, input int to, input bit hold);
    for (int i = from; i <= to; i++) begin
      tick();
      if (i == 1 && !hold) begin
        if (d == 0) bus_a.valid_i = 1'b0; else bus_b.valid_i = 1'b0;
      end
      ctx[i] = (d == 0) ? tx_a : tx_b;
      cdn[i] = (d == 0) ? done_a : done_b;
      crd[i] = (d == 0) ? bus_a.ready_o : bus_b.ready_o;
    end
  endtask

  function automatic logic [31:0] pack_tx(int n);
    logic [31:0] r;
    r = '0;
    for (int i = 1; i <= n; i++) r = {r[30:0], ctx[i]};
    return r;
  endfunction

  function automatic logic [31:0] pack_dn(int n);
    logic [31:0] r;
    r = '0;
    for (int i = 1; i <= n; i++) r = {r[30:0], cdn[i]};
    return r;
  endfunction

  // Receiver-side view: sample the first clock of each data bit
  function automatic logic [31:0] decode(int bc);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < int'(W); k++) r = {r[30:0], ctx[bc + 1 + k * bc]};
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    bcs[0] = 2; bcs[1] = 1;
    act[0] = 1'b0; act[1] = 1'b0;
    acc[0] = 0; acc[1] = 0;
    mdat[0] = '0; mdat[1] = '0;
    bus_a.data_i = '0; bus_a.valid_i = 1'b0;
    bus_b.data_i = '0; bus_b.valid_i = 1'b0;

    // Reset state
    #2 reset_ni = 1'b0;
    #1;
    chk("rst_tx",    32'(tx_a),          32'd0);
    chk("rst_ready", 32'(bus_a.ready_o), 32'd1);
    chk("rst_busy",  32'(busy_a),        32'd0);
    chk("rst_done",  32'(done_a),        32'd0);
    repeat (2) tick();
    reset_ni = 1'b1;
    tick();

    // Single frame 101
    send(0, 3'b101);
    cap(0, 1, 11, 1'b0);
    chk("f101_tx",   pack_tx(11), 32'(11'b11110011000));
    chk("f101_done", pack_dn(11), 32'(11'b00000000010));
    chk("f101_rdy11", 32'(crd[11]), 32'd1);
    chk("f101_rdy10", 32'(crd[10]), 32'd0);
    chk("loopback_a", decode(2), 32'd5);

    // Back-to-back 000 then 111 with valid held high
    send(0, 3'b000);
    cap(0, 1, 1, 1'b1);
    bus_a.data_i = 3'b111;
    cap(0, 2, 21, 1'b1);
    bus_a.valid_i = 1'b0;
    chk("b2b_tx",   pack_tx(21), 32'({10'b1100000000, 1'b0, 10'b1111111100}));
    chk("b2b_done", pack_dn(21), 32'({10'b0000000001, 1'b0, 10'b0000000001}));
    chk("b2b_gap",  32'({crd[10], crd[11], crd[12]}), 32'(3'b010));
    tick();

    // data/valid activity during a frame is ignored
    send(0, 3'b100);
    cap(0, 1, 2, 1'b0);
    bus_a.data_i = 3'b111; bus_a.valid_i = 1'b1;
    cap(0, 3, 3, 1'b1);
    bus_a.valid_i = 1'b0; bus_a.data_i = 3'b010;
    cap(0, 4, 5, 1'b1);
    bus_a.valid_i = 1'b1;
    cap(0, 6, 6, 1'b1);
    bus_a.valid_i = 1'b0;
    cap(0, 7, 13, 1'b1);
    chk("ign_tx", pack_tx(13), 32'(13'b1111000000000));
    chk("ign_done", pack_dn(13), 32'(13'b0000000001000));

    // Asynchronous abort during DATA of 110
    send(0, 3'b110);
    cap(0, 1, 4, 1'b0);
    chk("abort_pre_tx", 32'(ctx[4]), 32'd1);
    reset_ni = 1'b0;
    act[0] = 1'b0; act[1] = 1'b0;
    #1;
    chk("abort_tx",    32'(tx_a),          32'd0);
    chk("abort_busy",  32'(busy_a),        32'd0);
    chk("abort_ready", 32'(bus_a.ready_o), 32'd1);
    chk("abort_done",  32'(done_a),        32'd0);
    repeat (2) tick();
    reset_ni = 1'b1;
    tick();
    send(0, 3'b011);
    cap(0, 1, 11, 1'b0);
    chk("f011_tx",   pack_tx(11), 32'(11'b11001111000));
    chk("f011_done", pack_dn(11), 32'(11'b00000000010));

    // BIT_CYCLES=1 instance, 010
    send(1, 3'b010);
    cap(1, 1, 6, 1'b0);
    chk("bc1_tx",   pack_tx(6), 32'(6'b101000));
    chk("bc1_done", pack_dn(6), 32'(6'b000010));
    chk("bc1_rdy6", 32'(crd[6]), 32'd1);
    chk("loopback_b", decode(1), 32'd2);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
